// File: rtl/commit_writeback_if.sv
// Writeback/commit bundle: Mem-side instruction group in, register-file writes,
// redirect pulse and perf counters out. master = upstream pipeline, slave = commit stage.
interface commit_writeback_if #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    localparam int CNT_W = $clog2(LANES + 1);

    logic [LANES-1:0]                 i_valid;
    logic [LANES-1:0][XLEN-1:0]       i_pc;
    logic [LANES-1:0]                 i_half;
    logic [LANES-1:0][REG_IDX_W-1:0]  i_rd_idx;
    logic [LANES-1:0][1:0]            i_rd_sel;
    logic [LANES-1:0]                 i_except_valid;
    logic [LANES-1:0][3:0]            i_except_code;
    logic [LANES-1:0][XLEN-1:0]       i_data;

    logic [LANES-1:0]                 o_wb_valid;
    logic [LANES-1:0][REG_IDX_W-1:0]  o_wb_idx;
    logic [LANES-1:0][XLEN-1:0]       o_wb_data;
    logic                             o_flush;
    logic                             o_pc_alter;
    logic [XLEN-1:0]                  o_pc;
    logic [CNT_W-1:0]                 o_retire_cnt;
    logic [63:0]                      o_cycle;
    logic [63:0]                      o_instret;

    modport master (
        output i_valid, i_pc, i_half, i_rd_idx, i_rd_sel, i_except_valid, i_except_code, i_data,
        input  o_wb_valid, o_wb_idx, o_wb_data, o_flush, o_pc_alter, o_pc, o_retire_cnt,
               o_cycle, o_instret
    );

    modport slave (
        input  i_valid, i_pc, i_half, i_rd_idx, i_rd_sel, i_except_valid, i_except_code, i_data,
        output o_wb_valid, o_wb_idx, o_wb_data, o_flush, o_pc_alter, o_pc, o_retire_cnt,
               o_cycle, o_instret
    );
endinterface

// File: rtl/commit_writeback.sv
// Multi-lane commit stage: retires oldest survivors, resolves the oldest redirect, blanks
// FLUSH_SHADOW input cycles afterwards. Define COMMIT_PERF_CNT_EN for cycle/instret counters.

// Per-lane decode: redirect event, target and candidate register write.
module commit_lane #(
    parameter int         XLEN           = 32,
    parameter int         REG_IDX_W      = 5,
    parameter logic [3:0] EXCEPT_FLUSH   = 4'd14,
    parameter logic [3:0] EXCEPT_MISPRED = 4'd15
) (
    input  logic                 vld,
    input  logic [XLEN-1:0]      pc,
    input  logic                 half,
    input  logic [1:0]           rd_sel,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic                 exc_vld,
    input  logic [3:0]           exc_code,
    input  logic [XLEN-1:0]      data,
    output logic                 ev,
    output logic                 alter,
    output logic [XLEN-1:0]      tgt,
    output logic                 wr,
    output logic [XLEN-1:0]      wdata
);
    localparam logic [1:0] SEL_REG    = 2'd1;
    localparam logic [1:0] SEL_REG_PC = 2'd2;
    localparam logic [1:0] SEL_FLUSH  = 2'd3;

    logic [XLEN-1:0] link;
    logic            ev_fl;
    logic            ev_mp;

    always_comb begin
        link  = pc + (half ? XLEN'(2) : XLEN'(4));
        ev_fl = exc_vld && (exc_code == EXCEPT_FLUSH);
        ev_mp = exc_vld && (exc_code == EXCEPT_MISPRED);
        alter = ev_fl || ev_mp;
        ev    = vld && (alter || (rd_sel == SEL_FLUSH));
        tgt   = ev_mp ? data : link;
        wr    = vld && ((rd_sel == SEL_REG) || (rd_sel == SEL_REG_PC)) && (rd_idx != '0);
        wdata = (rd_sel == SEL_REG_PC) ? link : data;
    end
endmodule

module commit_writeback #(
    parameter int         LANES          = 2,
    parameter int         XLEN           = 32,
    parameter int         REG_IDX_W      = 5,
    parameter int         FLUSH_SHADOW   = 1,
    parameter logic [3:0] EXCEPT_FLUSH   = 4'd14,
    parameter logic [3:0] EXCEPT_MISPRED = 4'd15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    commit_writeback_if.slave  bus
);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int SH_W  = $clog2(FLUSH_SHADOW + 1);

    logic [SH_W-1:0]                 shadow_q, shadow_d;
    logic                            live;
    logic [LANES-1:0]                lane_vld, lane_ev, lane_alter, lane_wr, retire, squash;
    logic [LANES-1:0][XLEN-1:0]      lane_tgt, lane_wdata;

    logic [LANES-1:0]                wb_valid_d, wb_valid_q;
    logic [LANES-1:0][REG_IDX_W-1:0] wb_idx_d, wb_idx_q;
    logic [LANES-1:0][XLEN-1:0]      wb_data_d, wb_data_q;
    logic                            flush_d, flush_q;
    logic                            pc_alter_d, pc_alter_q;
    logic [XLEN-1:0]                 pc_d, pc_q;
    logic [CNT_W-1:0]                retire_cnt_d, retire_cnt_q;

    assign live     = (shadow_q == '0);
    assign lane_vld = {LANES{live}} & bus.i_valid;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        commit_lane #(
            .XLEN(XLEN), .REG_IDX_W(REG_IDX_W),
            .EXCEPT_FLUSH(EXCEPT_FLUSH), .EXCEPT_MISPRED(EXCEPT_MISPRED)
        ) u_lane (
            .vld(lane_vld[l]), .pc(bus.i_pc[l]), .half(bus.i_half[l]),
            .rd_sel(bus.i_rd_sel[l]), .rd_idx(bus.i_rd_idx[l]),
            .exc_vld(bus.i_except_valid[l]), .exc_code(bus.i_except_code[l]),
            .data(bus.i_data[l]),
            .ev(lane_ev[l]), .alter(lane_alter[l]), .tgt(lane_tgt[l]),
            .wr(lane_wr[l]), .wdata(lane_wdata[l])
        );
    end

    always_comb begin
        flush_d      = 1'b0;
        pc_alter_d   = 1'b0;
        pc_d         = '0;
        retire       = '0;
        squash       = '0;
        retire_cnt_d = '0;
        wb_valid_d   = '0;
        wb_idx_d     = '0;
        wb_data_d    = '0;

        // Lanes retire oldest-first up to and including the first redirect event.
        for (int l = 0; l < LANES; l++) begin
            if (lane_vld[l] && !flush_d) begin
                retire[l]    = 1'b1;
                retire_cnt_d = retire_cnt_d + CNT_W'(1);
                if (lane_ev[l]) begin
                    flush_d    = 1'b1;
                    pc_alter_d = lane_alter[l];
                    pc_d       = lane_alter[l] ? lane_tgt[l] : '0;
                end
            end
        end

        // A younger retiring write to the same register wins.
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < LANES; j++) begin
                if ((j > l) && retire[j] && lane_wr[j] && (bus.i_rd_idx[j] == bus.i_rd_idx[l]))
                    squash[l] = 1'b1;
            end
            wb_valid_d[l] = retire[l] && lane_wr[l] && !squash[l];
            if (wb_valid_d[l]) begin
                wb_idx_d[l]  = bus.i_rd_idx[l];
                wb_data_d[l] = lane_wdata[l];
            end
        end

        if (!live)
            shadow_d = shadow_q - SH_W'(1);
        else if (flush_d)
            shadow_d = SH_W'(FLUSH_SHADOW);
        else
            shadow_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q     <= '0;
            wb_valid_q   <= '0;
            wb_idx_q     <= '0;
            wb_data_q    <= '0;
            flush_q      <= 1'b0;
            pc_alter_q   <= 1'b0;
            pc_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            shadow_q     <= shadow_d;
            wb_valid_q   <= wb_valid_d;
            wb_idx_q     <= wb_idx_d;
            wb_data_q    <= wb_data_d;
            flush_q      <= flush_d;
            pc_alter_q   <= pc_alter_d;
            pc_q         <= pc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.o_wb_valid   = wb_valid_q;
    assign bus.o_wb_idx     = wb_idx_q;
    assign bus.o_wb_data    = wb_data_q;
    assign bus.o_flush      = flush_q;
    assign bus.o_pc_alter   = pc_alter_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_retire_cnt = retire_cnt_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] cycle_q, cycle_d, instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + 64'(retire_cnt_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign bus.o_cycle   = cycle_q;
    assign bus.o_instret = instret_q;
`else
    assign bus.o_cycle   = '0;
    assign bus.o_instret = '0;
`endif
endmodule

// File: doc/commit_writeback.md
# commit_writeback

Multi-lane, parametrised writeback/commit stage at the tail of the core pipeline, after Mem. Each cycle it accepts up to LANES in-order instructions, retires the oldest contiguous survivors to the integer register file, and resolves the oldest redirect event (icache flush or mispredict) into a registered flush/PC-redirect pulse. It then blanks a configurable number of following input cycles while the front end refills, and optionally maintains 64-bit cycle/instret counters.

## Interface
- LANES, 2, instructions presented per cycle; lane 0 is oldest.
- XLEN, 32, data/PC width.
- REG_IDX_W, 5, architectural register index width.
- FLUSH_SHADOW, 1, input cycles dropped after a flush; must be ≥1.
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_valid  in  LANES  per-lane instruction valid
- i_pc  in  LANES*XLEN  per-lane PC
- i_half  in  LANES  per-lane compressed (2-byte) instruction
- i_rd_idx  in  LANES*REG_IDX_W  destination register
- i_rd_sel  in  LANES*2  0 NONE, 1 REG, 2 REG_AND_PC, 3 FLUSH
- i_except_valid  in  LANES  exception present
- i_except_code  in  LANES*4  EXCEPT_* encoding from instr.svh
- i_data  in  LANES*XLEN  result data; mispredict target when code is EXCEPT_MISPRED
- o_wb_valid  out  LANES  register write enable per lane
- o_wb_idx  out  LANES*REG_IDX_W  write index
- o_wb_data  out  LANES*XLEN  write data
- o_flush  out  1  pipeline flush pulse
- o_pc_alter  out  1  PC redirect pulse
- o_pc  out  XLEN  redirect target
- o_retire_cnt  out  $clog2(LANES+1)  lanes retired this cycle
- o_cycle  out  64  cycle counter
- o_instret  out  64  retired-instruction counter

## Operation
- Live input: `live = shadow_cnt == 0`. When not live, all lanes are treated invalid, and `shadow_cnt` decrements.
- Per lane, a redirect event is any of:
  - `except_valid & code == EXCEPT_FLUSH`: target `pc + (half ? 2 : 4)`.
  - `except_valid & code == EXCEPT_MISPRED`: target `i_data`.
  - `rd_sel == FLUSH`: flush only, no PC alter.
- Other except codes cause no redirect.
- The oldest valid lane with an event is the winner.
- The winner itself retires, including its register write. All younger lanes are killed: no write, not counted.
- A lane writes when all hold: retiring, `rd_sel` is REG or REG_AND_PC, and `rd_idx != 0`.
  - REG_AND_PC data is `pc + (half ? 2 : 4)`; otherwise `i_data`.
- WAW squash: a retiring lane's write is suppressed if a younger retiring lane in the same group writes the same index.
- On a winner:
  - `o_flush = 1`.
  - `o_pc_alter` is 1 for EXCEPT_FLUSH/EXCEPT_MISPRED, 0 for an `rd_sel` FLUSH event.
  - `o_pc` = target when `o_pc_alter` is 1, else 0.
  - `shadow_cnt` loads FLUSH_SHADOW.
- Invalid lanes neither block nor win; gaps between valid lanes are allowed.
- `o_retire_cnt` = number of retiring lanes, counting lanes whose write was suppressed by rd=0 or WAW.

## Timing
- All outputs are registered: inputs sampled at edge N appear at edge N+1.
- `o_flush` and `o_pc_alter` are single-cycle pulses.
- In every cycle without a winner, and every non-live cycle, `o_flush`, `o_pc_alter` and `o_pc` are 0.
- During non-live cycles, outputs are 0 and counters still count cycles.
- Reset (async, any time, including mid-shadow): every output, `shadow_cnt`, `o_cycle` and `o_instret` go to 0 immediately.
- First live sample is the first edge after `i_rst` deasserts.
- `o_cycle` increments by 1 every clock out of reset. `o_instret` adds `o_retire_cnt`'s next value each edge.
- Both counters wrap modulo 2^64.
- Winner on the last live cycle before a new shadow: counter reloads. Shadow never extends itself, since no events are accepted while not live.

## Configuration
- COMMIT_PERF_CNT_EN defined: `o_cycle`/`o_instret` counters are implemented as above.
- Undefined: no counter flops; `o_cycle` and `o_instret` are tied to 0. `o_retire_cnt` is unaffected.

## Test plan
- **Plain retire.** LANES=2; lane0 REG x5=0x11, lane1 REG x6=0x22.
  - Next cycle: `o_wb_valid=2'b11`, idx 5/6, data 0x11/0x22.
  - `o_retire_cnt=2`, `o_flush=0`.
- **Mispredict kills younger lane.** Lane0 REG_AND_PC x1, pc 0x100, EXCEPT_MISPRED, data 0x200; lane1 REG x7.
  - `o_wb` lane0 x1=0x104; lane1 not written.
  - `o_flush=1`, `o_pc_alter=1`, `o_pc=0x200`, `o_retire_cnt=1`.
- **Compressed icache-flush target and shadow.** Lane0 invalid; lane1 half=1, pc 0x3FE, EXCEPT_FLUSH; FLUSH_SHADOW=2.
  - `o_pc=0x400`.
  - Next two input cycles are fully ignored (all outputs 0); the third is retired normally.
- **WAW and x0.** Lane0 REG x3=0xA, lane1 REG x3=0xB.
  - Only lane1 writes 0xB; `o_retire_cnt=2`.
  - Repeat with rd=x0 on both: no write, count 2.
- **rd_sel FLUSH.** Lane0 rd_sel FLUSH, no exception.
  - `o_flush=1`, `o_pc_alter=0`, `o_pc=0`.
- **Async reset mid-shadow and counters.** Assert `i_rst` between edges during shadow.
  - All outputs drop to 0 immediately.
  - With COMMIT_PERF_CNT_EN, after 10 cycles retiring 2/cycle: `o_cycle=10`, `o_instret=20`.
  - Without the macro, both read 0.
